// File: rtl/mdu_iter.sv
// Iterative radix-2 multiply/divide unit producing HI/LO for MULT/MULTU/DIV/DIVU, plus MTHI/MTLO writes.
// Latency: MTHI/MTLO one edge; multiply/divide 32 edges after the accepting edge, results and busy drop together.
// Backpressure: busy is high while iterating; any start seen while busy is dropped, so the requester must hold it.
module mdu_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_lo_q, neg_lo_d;    // negate product / quotient at the end
    logic                 neg_hi_q, neg_hi_d;    // negate remainder (dividend was negative)
    logic                 div0_q, div0_d;
    logic [WIDTH-1:0]     a_raw_q, a_raw_d;      // original dividend, returned in HI on divide-by-zero
    logic [WIDTH:0]       opnd_q, opnd_d;        // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0]   work_q, work_d;        // product, or {remainder, quotient}
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;

    // Operand conditioning: signs and magnitudes in WIDTH+1 bits so that -2^(WIDTH-1) is exact.
    logic                 signed_op;
    logic                 a_sgn, b_sgn;
    logic [WIDTH:0]       a_ext, b_ext;
    logic [WIDTH:0]       a_mag, b_mag;

    // Per-iteration datapath.
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_trial;
    logic [WIDTH:0]       div_diff;
    logic                 div_ge;
    logic [WIDTH:0]       rem_nx;
    logic [2*WIDTH-1:0]   div_next;
    logic [2*WIDTH-1:0]   step_w;

    // Sign fix-up of the final iteration result.
    logic [2*WIDTH-1:0]   prod_neg;
    logic [WIDTH-1:0]     quo_raw, rem_raw;
    logic [WIDTH-1:0]     fin_hi, fin_lo;

    logic                 unused_bits;

    // Signed/unsigned operand magnitudes for the op currently presented.
    always_comb begin
        signed_op = (op == OP_MULT) || (op == OP_DIV);
        a_sgn     = signed_op & A[WIDTH-1];
        b_sgn     = signed_op & B[WIDTH-1];
        a_ext     = {a_sgn, A};
        b_ext     = {b_sgn, B};
        a_mag     = a_sgn ? (~a_ext + (WIDTH+1)'(1)) : a_ext;
        b_mag     = b_sgn ? (~b_ext + (WIDTH+1)'(1)) : b_ext;
    end

    // One radix-2 step: shift-add for multiply, restoring shift-subtract for divide.
    always_comb begin
        mul_sum   = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? opnd_q : '0);
        mul_next  = {mul_sum, work_q[WIDTH-1:1]};

        div_trial = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
        div_ge    = (div_trial >= opnd_q);
        div_diff  = div_trial - opnd_q;
        rem_nx    = div_ge ? div_diff : div_trial;
        div_next  = {rem_nx[WIDTH-1:0], work_q[WIDTH-2:0], div_ge};

        step_w    = is_div_q ? div_next : mul_next;
    end

    // Apply result signs (and the divide-by-zero convention) to the last step's output.
    always_comb begin
        prod_neg = ~step_w + (2*WIDTH)'(1);
        quo_raw  = step_w[WIDTH-1:0];
        rem_raw  = step_w[2*WIDTH-1:WIDTH];
        fin_hi   = rem_raw;
        fin_lo   = quo_raw;
        if (!is_div_q) begin
            {fin_hi, fin_lo} = neg_lo_q ? prod_neg : step_w;
        end else if (div0_q) begin
            fin_hi = a_raw_q;
            fin_lo = '1;
        end else begin
            fin_lo = neg_lo_q ? (~quo_raw + WIDTH'(1)) : quo_raw;
            fin_hi = neg_hi_q ? (~rem_raw + WIDTH'(1)) : rem_raw;
        end
    end

    // Next-state: accept ops in IDLE, iterate in RUN, commit HI/LO on the last step.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        div0_d   = div0_q;
        a_raw_d  = a_raw_q;
        opnd_d   = opnd_q;
        work_d   = work_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            state_d  = S_RUN;
                            cnt_d    = CNT_W'(WIDTH);
                            is_div_d = 1'b0;
                            neg_lo_d = a_sgn ^ b_sgn;
                            neg_hi_d = 1'b0;
                            div0_d   = 1'b0;
                            opnd_d   = a_mag;
                            work_d   = {{WIDTH{1'b0}}, b_mag[WIDTH-1:0]};
                        end
                        OP_DIV, OP_DIVU: begin
                            state_d  = S_RUN;
                            cnt_d    = CNT_W'(WIDTH);
                            is_div_d = 1'b1;
                            neg_lo_d = a_sgn ^ b_sgn;
                            neg_hi_d = a_sgn;
                            div0_d   = (B == '0);
                            a_raw_d  = A;
                            opnd_d   = b_mag;
                            work_d   = {{WIDTH{1'b0}}, a_mag[WIDTH-1:0]};
                        end
                        OP_MTHI: hi_d = A;
                        OP_MTLO: lo_d = A;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                work_d = step_w;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_IDLE;
                    hi_d    = fin_hi;
                    lo_d    = fin_lo;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, datapath and architectural registers; reset discards any op in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            div0_q   <= 1'b0;
            a_raw_q  <= '0;
            opnd_q   <= '0;
            work_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            div0_q   <= div0_d;
            a_raw_q  <= a_raw_d;
            opnd_q   <= opnd_d;
            work_q   <= work_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    // The selected partial remainder never exceeds WIDTH bits; its top bit is structurally zero.
    assign unused_bits = rem_nx[WIDTH];

    assign busy = (state_q == S_RUN);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
